// File: rtl/display_pkg.sv
// Shared constants for the display blocks: anode polarity, default scan timing, nibble width.
package display_pkg;
  localparam logic ANODE_OFF = 1'b1;
  localparam logic ANODE_ON  = 1'b0;

  localparam int DEFAULT_REFRESH_DIV = 100000;
  localparam int DEFAULT_GUARD       = 16;
  localparam int NIB_W               = 4;

  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/refresh_divider.sv
// Free-running 0..DIV-1 counter with a wrap flag that is high during the last count.
// Synchronous active-high reset.
module refresh_divider
  import display_pkg::*;
#(
  parameter int DIV = DEFAULT_REFRESH_DIV,
  localparam int CW = min1_clog2(DIV)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic [CW-1:0] cnt_o,
  output logic          wrap_o
);
  logic [CW-1:0] cnt_q;

  assign wrap_o = (cnt_q == CW'(DIV - 1));
  assign cnt_o  = cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= wrap_o ? '0 : cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/display_scan_mux.sv
// Multiplexed seven-segment digit scanner with frame-boundary double buffering.
// Optional leading-zero blanking when LEADING_ZERO_BLANK_EN is defined.
module display_scan_mux
  import display_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV,
  parameter int GUARD       = DEFAULT_GUARD
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic [NIB_W*NUM_DIGITS-1:0] value,
  input  logic                        load,
  output logic [NIB_W-1:0]            numout,
  output logic [NUM_DIGITS-1:0]       an,
  output logic                        frame_start,
  output logic                        busy
);
  localparam int CW = min1_clog2(REFRESH_DIV);
  localparam int IW = min1_clog2(NUM_DIGITS);

  logic [CW-1:0] cnt;
  logic          wrap;

  refresh_divider #(.DIV(REFRESH_DIV)) u_div (
    .clk_i (Clk),
    .rst_i (Rst),
    .cnt_o (cnt),
    .wrap_o(wrap)
  );

  logic [IW-1:0]                        idx_q, idx_d;
  logic [NUM_DIGITS-1:0][NIB_W-1:0]     disp_q, disp_d, pend_q, pend_d;
  logic                                 busy_q, busy_d, fs_q;
  logic [NIB_W-1:0]                     num_q, num_d;
  logic [NUM_DIGITS-1:0]                an_q, an_d, blank_d;
  logic                                 last_digit, boundary, lit_d;
`ifdef LEADING_ZERO_BLANK_EN
  logic                                 zero_above;
`endif

  always_comb begin
    last_digit = (idx_q == IW'(NUM_DIGITS - 1));
    boundary   = wrap && last_digit;

    idx_d = idx_q;
    if (wrap) idx_d = last_digit ? '0 : idx_q + 1'b1;

    disp_d = disp_q;
    pend_d = pend_q;
    busy_d = busy_q;
    if (boundary) begin
      // A load landing on the boundary bypasses the pending buffer.
      if (load) disp_d = value;
      else if (busy_q) disp_d = pend_q;
      busy_d = 1'b0;
    end else if (load) begin
      pend_d = value;
      busy_d = 1'b1;
    end

    blank_d = '0;
`ifdef LEADING_ZERO_BLANK_EN
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above && (disp_d[i] == '0);
      blank_d[i] = zero_above;
    end
`endif

    // Outputs are registered, so decide lighting from the next-cycle count.
    lit_d = wrap ? (GUARD == 0) : (int'(cnt) + 1 >= GUARD);
    an_d  = {NUM_DIGITS{ANODE_OFF}};
    if (lit_d && !blank_d[idx_d]) an_d[idx_d] = ANODE_ON;

    num_d = disp_d[idx_d];
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      idx_q  <= '0;
      disp_q <= '0;
      pend_q <= '0;
      busy_q <= 1'b0;
      fs_q   <= 1'b0;
      num_q  <= '0;
      an_q   <= {NUM_DIGITS{ANODE_OFF}};
    end else begin
      idx_q  <= idx_d;
      disp_q <= disp_d;
      pend_q <= pend_d;
      busy_q <= busy_d;
      fs_q   <= boundary;
      num_q  <= num_d;
      an_q   <= an_d;
    end
  end

  assign numout      = num_q;
  assign an          = an_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;
endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux: cycle-count model checked every cycle plus literal spot checks.
module tb_display_scan_mux;
  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int GUARD = 1;
  localparam int FRAME = N * DIV;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic [3:0]  numout;
  logic [3:0]  an;
  logic        frame_start;
  logic        busy;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model state: cycles since reset release, frame on display, latest pending load.
  int          m_k = 0;
  logic [15:0] m_shown = '0;
  logic [15:0] m_pend = '0;
  bit          m_have = 1'b0;

  display_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .GUARD(GUARD)) dut (
    .Clk(Clk), .Rst(Rst), .value(value), .load(load),
    .numout(numout), .an(an), .frame_start(frame_start), .busy(busy)
  );

  initial forever #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (Rst) begin
      m_k = 0; m_shown = '0; m_pend = '0; m_have = 1'b0;
    end else begin
      if (load) begin m_pend = value; m_have = 1'b1; end
      if (m_k % FRAME == FRAME - 1) begin
        if (m_have) m_shown = m_pend;
        m_have = 1'b0;
      end
      m_k++;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (k=%0d)", name, act, exp, m_k);
    end
  endtask

  function automatic logic [3:0] exp_an();
    int  d;
    bit  blank;
    logic [3:0] one;
    d = (m_k / DIV) % N;
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    blank = (d > 0) && ((m_shown >> (4 * d)) == 16'h0);
`endif
    one = 4'b0001;
    if ((m_k % DIV) >= GUARD && !blank) return ~(one << d);
    return 4'b1111;
  endfunction

  always @(negedge Clk) begin
    if (chk_en) begin
      check("cmp_numout", {12'h0, numout}, {12'h0, m_shown[4 * ((m_k / DIV) % N) +: 4]});
      check("cmp_an", {12'h0, an}, {12'h0, exp_an()});
      check("cmp_frame_start", {15'h0, frame_start}, {15'h0, (m_k > 0 && m_k % FRAME == 0)});
      check("cmp_busy", {15'h0, busy}, {15'h0, m_have});
    end
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic adv_to(input int target);
    int n = 0;
    while (m_k != target && n < 200) begin
      tick();
      n++;
    end
    check("adv_to_timeout", 16'(m_k), 16'(target));
  endtask

  task automatic do_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  logic [3:0] seq_num [4];
  logic [3:0] seq_an  [4];
  logic [3:0] an_d1;

  initial begin
    seq_num = '{4'hF, 4'hA, 4'h2, 4'h1};
    seq_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
`ifdef LEADING_ZERO_BLANK_EN
    an_d1 = 4'b1111;
`else
    an_d1 = 4'b1101;
`endif

    tick();
    chk_en = 1'b1;
    tick(); tick();
    check("rst_an", {12'h0, an}, 16'h000F);
    check("rst_numout", {12'h0, numout}, 16'h0);
    check("rst_busy", {15'h0, busy}, 16'h0);

    Rst = 1'b0;
    tick();
    check("first_lit_an", {12'h0, an}, 16'h000E);
    adv_to(4);
    check("guard_an", {12'h0, an}, 16'h000F);
    adv_to(5);
    check("digit1_an", {12'h0, an}, 16'h000D);

    do_load(16'h12AF);
    check("pending_busy", {15'h0, busy}, 16'h1);
    adv_to(16);
    check("boundary_fs", {15'h0, frame_start}, 16'h1);
    check("boundary_busy", {15'h0, busy}, 16'h0);
    for (int d = 0; d < 4; d++) begin
      adv_to(16 + 4 * d + 1);
      check("seq_numout", {12'h0, numout}, {12'h0, seq_num[d]});
      check("seq_an", {12'h0, an}, {12'h0, seq_an[d]});
    end

    adv_to(34); do_load(16'h1111);
    adv_to(38); do_load(16'h2222);
    adv_to(49);
    check("last_load_wins", {12'h0, numout}, 16'h2);

    adv_to(63); do_load(16'h00C3);
    check("edge_load_busy", {15'h0, busy}, 16'h0);
    check("edge_load_num", {12'h0, numout}, 16'h3);
    adv_to(69);
    check("edge_load_d1", {12'h0, numout}, 16'hC);

    adv_to(70); do_load(16'h0005);
    adv_to(81);
    check("lz5_d0_an", {12'h0, an}, 16'h000E);
    check("lz5_d0_num", {12'h0, numout}, 16'h5);
    adv_to(85);
    check("lz5_d1_an", {12'h0, an}, {12'h0, an_d1});
    adv_to(86); do_load(16'h0000);
    adv_to(97);
    check("lz0_d0_an", {12'h0, an}, 16'h000E);
    check("lz0_d0_num", {12'h0, numout}, 16'h0);
    adv_to(101);
    check("lz0_d1_an", {12'h0, an}, {12'h0, an_d1});

    adv_to(102); do_load(16'hABCD);
    check("pre_rst_busy", {15'h0, busy}, 16'h1);
    tick(); tick();
    Rst = 1'b1;
    tick();
    check("midrst_an", {12'h0, an}, 16'h000F);
    check("midrst_num", {12'h0, numout}, 16'h0);
    check("midrst_busy", {15'h0, busy}, 16'h0);
    check("midrst_fs", {15'h0, frame_start}, 16'h0);
    Rst = 1'b0;
    adv_to(13);
    check("post_rst_d3_an", {12'h0, an}, 16'h0007);
    check("post_rst_d3_num", {12'h0, numout}, 16'h0);
    adv_to(40);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/display_scan_mux.md
# display_scan_mux

Time-multiplexed digit scanner that sits directly upstream of the seven-segment decoder. Holds a frame of NUM_DIGITS hex nibbles and walks through the digits one at a time. For each digit it presents that nibble on `numout` (wired to the decoder's 4-bit input) and asserts the matching active-low anode, so one decoder drives a whole multi-digit display. New values are double-buffered and applied only at frame boundaries, so the display never tears.

## Interface
- NUM_DIGITS, 8, number of digits scanned (2..8)
- REFRESH_DIV, 100000, clock cycles each digit stays selected (≥ GUARD+2)
- GUARD, 16, cycles at the start of each digit slot with all anodes off (anti-ghosting)
- Clk  in  1  system clock, all state on rising edge
- Rst  in  1  synchronous, active-high reset
- value  in  4*NUM_DIGITS  frame to display; digit i = value[4i+3:4i], digit 0 rightmost
- load  in  1  one-cycle strobe; captures `value` into the pending buffer
- numout  out  4  nibble of currently selected digit, to decoder input
- an  out  NUM_DIGITS  anode enables, active-low, at most one bit low
- frame_start  out  1  one-cycle pulse when the scan wraps to digit 0
- busy  out  1  high while a loaded value is pending and not yet displayed

## Operation
- Refresh counter `cnt` counts 0..REFRESH_DIV-1 and wraps. On the wrap cycle (cnt == REFRESH_DIV-1), digit index `idx` increments; NUM_DIGITS-1 wraps to 0.
- `numout` = disp[idx], registered, and updates in the same edge as `idx`.
- `an[idx]` is low only while cnt ≥ GUARD and the digit is not blanked. All other anode bits are 1.
- Frame boundary: the edge where idx goes NUM_DIGITS-1 → 0. At that edge:
  - disp takes `value` directly if `load` is high in that cycle;
  - otherwise disp takes the pending buffer if `busy` is set.
  - `busy` clears and `frame_start` pulses for the following cycle.
- `load` on any other cycle writes pending and sets `busy`. A second load before the boundary overwrites pending; the last value wins.
- Reset values: cnt=0, idx=0, disp=0, pending=0, busy=0, numout=0, an=all 1, frame_start=0.
- Reset asserted mid-scan or mid-pending returns every register to its reset value on the next edge and discards the pending value.
- All widths are unsigned. cnt width is $clog2(REFRESH_DIV) and idx width is $clog2(NUM_DIGITS), with a minimum of 1.

## Timing
- Load-to-display latency: from the load edge to the next frame boundary, at most NUM_DIGITS*REFRESH_DIV cycles.
- First anode low: cycle GUARD after reset release, for digit 0.
- Each digit is lit for REFRESH_DIV-GUARD cycles per slot. One frame is NUM_DIGITS*REFRESH_DIV cycles.
- `numout` is stable for the whole slot, including the guard interval.
- `frame_start` is high exactly one cycle per frame and never during reset.

## Configuration
- LEADING_ZERO_BLANK_EN defined: any digit i > 0 whose nibble and all higher nibbles in disp are 0 is blanked, meaning its anode stays 1 for the whole slot. Digit 0 is never blanked. The blank mask is derived from disp, so it changes only at frame boundaries.
- Undefined: no blanking; every digit is lit.

## Structure
- Shared package `display_pkg`:
  - ANODE_OFF (1'b1) and ANODE_ON (1'b0);
  - default REFRESH_DIV and GUARD constants;
  - the nibble width (4).
- One sub-module, `refresh_divider`. Parameter DIV, outputs cnt and a wrap pulse. Reused by other display blocks.
- Digit-select, double buffering and anode logic stay in the top level.

## Test plan
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=4, GUARD=1.
- Reset -> an=4'b1111, numout=0, busy=0. Release reset -> an=4'b1110 on cycle 1, idx advances every 4 cycles.
- Load value=16'h12AF mid-frame -> busy=1. At the next boundary numout sequence F,A,2,1 with an 1110,1101,1011,0111, frame_start pulses, busy=0.
- Loads 16'h1111 then 16'h2222 in one frame -> only 2222 is ever displayed.
- Load asserted exactly on the boundary cycle with value=16'h00C3 -> displayed from digit 0 of the new frame; busy stays 0.
- With LEADING_ZERO_BLANK_EN, value=16'h0005 -> digits 3..1 keep an high all frame and digit 0 is lit. value=16'h0000 -> only digit 0 is lit, showing 0.
- Rst pulse mid-slot with busy=1 -> all outputs return to reset values and the pending value is never displayed.
